// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue: sequential 16-bit reads into an 8-byte queue, oldest 4 bytes shown as op.
// Latency: op/op_ok are combinational from the queue registers; even start op_ok 2 edges after first bus_ok.
// Backpressure: reads are requested only while at least 2 bytes stay free after this cycle's consume.
module jt900h_prefetch #(
    parameter logic [23:0] RST_PC = 24'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [1:0]  fetched,
    input  logic        pc_we,
    input  logic [23:0] pc_din,
    output logic [23:0] pc,
    output logic [31:0] op,
    output logic        op_ok,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    input  logic [15:0] bus_din,
    input  logic        bus_ok
);

    logic [7:0]  r_buf [0:7];
    logic [3:0]  r_cnt;
    logic [23:0] r_pc;
    logic [23:0] r_rd_addr;
    logic        r_skip;
    logic        r_bus_rd;

    logic [3:0]  w_fetched_eff;
    logic        w_append;
    logic [3:0]  w_add;
    logic [3:0]  w_pos;
    logic [3:0]  w_cnt_nxt;
    logic [7:0]  w_buf_nxt [0:7];

    assign op       = {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
    assign op_ok    = (r_cnt >= 4'd4);
    assign pc       = r_pc;
    assign bus_addr = r_rd_addr;
    assign bus_rd   = r_bus_rd;

    // Next queue contents: drop consumed bytes, then append returned bus data after the survivors.
    always_comb begin
        w_fetched_eff = op_ok ? {2'b00, fetched} : 4'd0;
        w_append      = r_bus_rd & bus_ok;
        w_add         = w_append ? (r_skip ? 4'd1 : 4'd2) : 4'd0;
        w_pos         = r_cnt - w_fetched_eff;
        w_cnt_nxt     = w_pos + w_add;
        for (int i = 0; i < 8; i++) begin
            if ((i + int'(w_fetched_eff)) < 8) begin
                w_buf_nxt[i] = r_buf[3'(i + int'(w_fetched_eff))];
            end else begin
                w_buf_nxt[i] = 8'h00;
            end
            if (w_append) begin
                if (r_skip) begin
                    // Odd start: the low byte of the first word precedes the target PC.
                    if (4'(i) == w_pos) w_buf_nxt[i] = bus_din[15:8];
                end else begin
                    if (4'(i) == w_pos)        w_buf_nxt[i] = bus_din[7:0];
                    if (4'(i) == w_pos + 4'd1) w_buf_nxt[i] = bus_din[15:8];
                end
            end
        end
    end

    // Queue, PC, read address and request state; a jump overrides consume and data return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
            r_cnt     <= 4'd0;
            r_pc      <= RST_PC;
            r_rd_addr <= {RST_PC[23:1], 1'b0};
            r_skip    <= RST_PC[0];
            r_bus_rd  <= 1'b0;
        end else if (cen) begin
            if (pc_we) begin
                r_cnt     <= 4'd0;
                r_pc      <= pc_din;
                r_rd_addr <= {pc_din[23:1], 1'b0};
                r_skip    <= pc_din[0];
                r_bus_rd  <= 1'b0;
            end else begin
                r_buf    <= w_buf_nxt;
                r_cnt    <= w_cnt_nxt;
                r_pc     <= r_pc + {20'd0, w_fetched_eff};
                r_bus_rd <= (w_cnt_nxt <= 4'd6);
                if (w_append) begin
                    r_rd_addr <= r_rd_addr + 24'd2;
                    r_skip    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Bench for the prefetch queue: memory responder, ideal byte-stream model and scoreboard monitor.
// Latency: checks sampled on the falling edge, inputs driven 2 time units after the rising edge.
// Backpressure: bus stalls and clock-enable gaps are injected by the responder and the driver.
module tb_jt900h_prefetch;
    localparam logic [23:0] RST_PC = 24'h000100;

    logic        clk = 1'b0;
    logic        rst, cen, pc_we, op_ok, bus_rd, bus_ok;
    logic [1:0]  fetched;
    logic [23:0] pc_din, pc, bus_addr;
    logic [31:0] op;
    logic [15:0] bus_din;

    int checks = 0;
    int errors = 0;
    int bus_mode = 0;
    int stall = 0;

    // Reference model: ideal byte stream starting at the current PC, plus occupancy bookkeeping.
    logic [7:0]  exp_q[$];
    logic [23:0] exp_pc, next_addr, exp_rd;
    int          mcnt;
    bit          mskip, exp_bus_rd;

    jt900h_prefetch #(.RST_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .cen(cen), .fetched(fetched),
        .pc_we(pc_we), .pc_din(pc_din), .pc(pc), .op(op), .op_ok(op_ok),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_din(bus_din), .bus_ok(bus_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h12;
            24'h000101: return 8'h34;
            24'h000102: return 8'h56;
            24'h000103: return 8'h78;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return {mem_byte({a[23:1], 1'b1}), mem_byte({a[23:1], 1'b0})};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(mem_byte(next_addr));
            next_addr = next_addr + 24'd1;
        end
    endtask

    task automatic model_jump(input logic [23:0] a);
        exp_q.delete();
        exp_pc     = a;
        next_addr  = a;
        top_up();
        mcnt       = 0;
        mskip      = a[0];
        exp_rd     = {a[23:1], 1'b0};
        exp_bus_rd = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_op_ok();
        for (int i = 0; i < 100; i++) begin
            if (op_ok) break;
            tick();
        end
        chk("op_ok_wait", op_ok, 1);
    endtask

    // Model update on every enabled edge.
    initial begin
        int fe;
        model_jump(RST_PC);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_jump(RST_PC);
            end else if (cen) begin
                if (pc_we) begin
                    model_jump(pc_din);
                end else begin
                    fe = (mcnt >= 4) ? int'(fetched) : 0;
                    repeat (fe) void'(exp_q.pop_front());
                    exp_pc = exp_pc + 24'(fe);
                    top_up();
                    mcnt = mcnt - fe;
                    if (exp_bus_rd && bus_ok) begin
                        mcnt   = mcnt + (mskip ? 1 : 2);
                        mskip  = 1'b0;
                        exp_rd = exp_rd + 24'd2;
                    end
                    exp_bus_rd = (mcnt <= 6);
                end
            end
        end
    end

    // Scoreboard monitor: compare DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("pc", pc, exp_pc);
                chk("op_ok", op_ok, mcnt >= 4);
                chk("bus_rd", bus_rd, exp_bus_rd);
                if (exp_bus_rd) chk("bus_addr", bus_addr, exp_rd);
                if (mcnt >= 4) chk("op", op, {exp_q[3], exp_q[2], exp_q[1], exp_q[0]});
            end
        end
    end

    // Memory responder: holds bus_ok/bus_din across disabled edges.
    initial begin
        logic cen_s;
        bus_ok  = 1'b0;
        bus_din = 16'h0000;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                bus_ok = 1'b0;
            end else begin
                cen_s = cen;
                #1;
                if (rst) begin
                    bus_ok = 1'b0;
                end else if (cen_s) begin
                    if (stall > 0) begin
                        stall--;
                        bus_ok = 1'b0;
                    end else begin
                        bus_ok = bus_rd && (bus_mode == 0 || $urandom_range(0, 2) != 0);
                    end
                    bus_din = mem_word(bus_addr);
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int fs [4] = '{1, 2, 3, 0};
        logic [23:0] pcs [4] = '{24'h000101, 24'h000103, 24'h000106, 24'h000106};
        int drops;
        bit found;

        rst = 1'b1; cen = 1'b1; fetched = 2'd0; pc_we = 1'b0; pc_din = 24'h0;
        #3;
        chk("rst_op", op, 32'h0);
        chk("rst_op_ok", op_ok, 0);
        chk("rst_bus_rd", bus_rd, 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_bus_addr", bus_addr, 24'h000100);
        #9;
        rst = 1'b0;

        // Startup with a zero-wait bus.
        tick(); #1;
        chk("first_bus_rd", bus_rd, 1);
        tick(); tick(); #1;
        chk("start_op_ok", op_ok, 1);
        chk("start_op", op, 32'h78563412);
        chk("start_pc", pc, 24'h000100);

        // Consume 1, 2, 3, 0 bytes.
        for (int k = 0; k < 4; k++) begin
            fetched = fs[k];
            tick(); #1;
            chk("consume_pc", pc, pcs[k]);
            chk("consume_op0", op[7:0], mem_byte(pcs[k]));
        end
        fetched = 2'd0;
        repeat (4) tick();
        #1;
        chk("full_pause_bus_rd", bus_rd, 0);
        chk("full_op_ok", op_ok, 1);

        // Jump while a read is being returned.
        fetched = 2'd2;
        tick();
        fetched = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_rd && bus_ok) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("pending_read_seen", found, 1);
        pc_we = 1'b1; pc_din = 24'h000201; fetched = 2'd3;
        tick();
        pc_we = 1'b0; fetched = 2'd0;
        #1;
        chk("flush_bus_rd", bus_rd, 0);
        chk("flush_pc", pc, 24'h000201);
        chk("flush_op_ok", op_ok, 0);
        tick(); #1;
        chk("restart_bus_rd", bus_rd, 1);
        chk("restart_bus_addr", bus_addr, 24'h000200);
        wait_op_ok();
        chk("jump_op0", op[7:0], mem_byte(24'h000201));
        chk("jump_pc", pc, 24'h000201);

        // Address wrap.
        pc_we = 1'b1; pc_din = 24'hFFFFFE;
        tick();
        pc_we = 1'b0;
        wait_op_ok();
        chk("wrap_op", op, {mem_byte(24'h000001), mem_byte(24'h000000),
                            mem_byte(24'hFFFFFF), mem_byte(24'hFFFFFE)});

        // Bus stall with clock enable toggling.
        pc_we = 1'b1; pc_din = 24'h000300;
        tick();
        pc_we = 1'b0;
        stall = 5;
        for (int i = 0; i < 4; i++) begin
            cen = ~cen;
            tick();
        end
        #1;
        chk("stall_op_ok", op_ok, 0);
        for (int i = 0; i < 60; i++) begin
            if (op_ok) break;
            cen = ~cen;
            tick();
        end
        chk("stall_recover", op_ok, 1);
        cen = 1'b1;

        // Steady streaming with at most 2 bytes consumed per cycle.
        pc_we = 1'b1; pc_din = 24'h000400;
        tick();
        pc_we = 1'b0;
        wait_op_ok();
        drops = 0;
        for (int i = 0; i < 200; i++) begin
            fetched = 2'($urandom_range(0, 2));
            tick();
            if (!op_ok) drops++;
        end
        chk("steady_op_ok_drops", drops, 0);
        fetched = 2'd0;

        // Random traffic.
        bus_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            cen     = ($urandom_range(0, 3) != 0);
            fetched = 2'($urandom_range(0, 3));
            pc_we   = ($urandom_range(0, 63) == 0);
            pc_din  = ($urandom_range(0, 1) != 0) ? 24'($urandom)
                                                  : 24'hFFFFF8 + 24'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) stall = $urandom_range(1, 6);
            tick();
        end
        pc_we = 1'b0; cen = 1'b1; fetched = 2'd0; bus_mode = 0;
        repeat (10) tick();

        // Reset while a read is pending with 6 bytes queued.
        pc_we = 1'b1; pc_din = 24'h000500;
        tick();
        pc_we = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mcnt == 6 && bus_rd) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_setup_six_bytes", found, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_op_ok", op_ok, 0);
        chk("midrst_bus_rd", bus_rd, 0);
        chk("midrst_pc", pc, RST_PC);
        #2;
        rst = 1'b0;
        wait_op_ok();
        chk("rerun_op", op, 32'h78563412);
        chk("rerun_pc", pc, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
